// File: rtl/temp_display_scan_ctrl.sv
// rtl/temp_display_scan_ctrl.sv - two-digit temperature readout: BCD conversion FSM plus multiplexed 7-segment scanner
//
// Accepts 5-bit binary samples over valid/ready and converts each one to tens/ones
// by repeated subtraction of 10. The result drives a shared active-low segment bus
// that alternates between the ones and tens digits. The bus applies leading-zero
// blanking and blinks when the sample is at or above the alarm threshold.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample       binary temperature 0..31
//   sample_valid producer presents a sample
//   sample_ready controller can accept a sample (registered)
//   seg          shared segments, active-low, gfedcba
//   digit_en     active-low digit enables, [0]=ones, [1]=tens
//   alarm        over-threshold flag for the displayed value
//   busy         conversion in progress
module temp_display_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_DIV    = 64,
  parameter int ALARM_THRESH = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       alarm,
  output logic       busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [4:0]    work;
  logic [4:0]    held;
  logic [1:0]    tens;
  logic [3:0]    disp_ones;
  logic [1:0]    disp_tens;
  logic          has_value;

  logic [SW-1:0] scan_cnt;
  logic          slot;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          accept;
  logic          scan_wrap;
  logic          blink_wrap;
  logic          over_thresh;

  // Display contents as they will be after this edge; lets a COMMIT reach the
  // pins on the same edge that loads the display registers.
  logic          nxt_has;
  logic [3:0]    nxt_ones;
  logic [1:0]    nxt_tens;
  logic          nxt_alarm;
  logic [6:0]    seg_nxt;
  logic [1:0]    en_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  assign accept      = sample_valid && sample_ready;
  assign scan_wrap   = (scan_cnt == SW'(SCAN_DIV - 1));
  assign blink_wrap  = (blink_cnt == BW'(BLINK_DIV - 1));
  assign over_thresh = (held >= 5'(ALARM_THRESH));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_CONVERT;
      S_CONVERT: if (work < 5'd10) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      sample_ready <= 1'b1;
      work         <= 5'd0;
      held         <= 5'd0;
      tens         <= 2'd0;
      disp_ones    <= 4'd0;
      disp_tens    <= 2'd0;
      has_value    <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      sample_ready <= (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            work <= sample;
            held <= sample;
            tens <= 2'd0;
          end
        end
        S_CONVERT: begin
          if (work >= 5'd10) begin
            work <= work - 5'd10;
            tens <= tens + 2'd1;
          end
        end
        S_COMMIT: begin
          // work is below 10 here, so its low nibble is the ones digit
          disp_ones <= work[3:0];
          disp_tens <= tens;
          alarm     <= over_thresh;
          has_value <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_has   = has_value;
    nxt_ones  = disp_ones;
    nxt_tens  = disp_tens;
    nxt_alarm = alarm;
    if (state == S_COMMIT) begin
      nxt_has   = 1'b1;
      nxt_ones  = work[3:0];
      nxt_tens  = tens;
      nxt_alarm = over_thresh;
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    en_nxt  = 2'b11;
    if (nxt_has && !(nxt_alarm && blink_phase)) begin
      if (!slot) begin
        seg_nxt = seg_code(nxt_ones);
        en_nxt  = 2'b10;
      end else if (nxt_tens != 2'd0) begin
        seg_nxt = seg_code({2'b00, nxt_tens});
        en_nxt  = 2'b01;
      end
    end
  end

  // Scanner free-runs regardless of the conversion FSM; the pins follow the slot
  // register one edge after it toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      slot        <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg         <= SEG_BLANK;
      digit_en    <= 2'b11;
    end else begin
      seg      <= seg_nxt;
      digit_en <= en_nxt;
      if (scan_wrap) begin
        scan_cnt <= '0;
        slot     <= ~slot;
        if (blink_wrap) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_temp_display_scan_ctrl.sv
// tb/tb_temp_display_scan_ctrl.sv - self-checking bench for temp_display_scan_ctrl
module tb_temp_display_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_DIV    = 2;
  localparam int ALARM_THRESH = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       alarm;
  logic       busy;

  temp_display_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV),
    .ALARM_THRESH(ALARM_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample(sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .seg(seg),
    .digit_en(digit_en),
    .alarm(alarm),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int acc_cyc;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_count = 0;
  int    last_commit_cyc = 0;
  bit    prev_busy = 1'b0;
  bit    exp_has = 1'b0;
  bit    exp_alarm = 1'b0;
  int    exp_ones = 0;
  int    exp_tens = 0;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0:       enc = 7'b1000000;
      1:       enc = 7'b1111001;
      2:       enc = 7'b0100100;
      3:       enc = 7'b0110000;
      4:       enc = 7'b0011001;
      5:       enc = 7'b0010010;
      6:       enc = 7'b0000010;
      7:       enc = 7'b1111000;
      8:       enc = 7'b0000000;
      9:       enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected pins after edge cyc: the slot and blink phase visible now are the
  // ones the scanner held after the previous edge.
  task automatic check_outputs;
    logic [6:0] es;
    logic [1:0] ee;
    int slot_v;
    int blink_v;
    es = 7'b1111111;
    ee = 2'b11;
    if (cyc > 0 && exp_has) begin
      slot_v  = ((cyc - 1) / SCAN_DIV) % 2;
      blink_v = ((cyc - 1) / (SCAN_DIV * BLINK_DIV)) % 2;
      if (!(exp_alarm && blink_v == 1)) begin
        if (slot_v == 0) begin
          es = enc(exp_ones);
          ee = 2'b10;
        end else if (exp_tens != 0) begin
          es = enc(exp_tens);
          ee = 2'b01;
        end
      end
    end
    chk("seg", 32'(seg), 32'(es));
    chk("digit_en", 32'(digit_en), 32'(ee));
    chk("alarm", 32'(alarm), 32'(exp_alarm));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("sample_ready", 32'(sample_ready), 32'(q.size() == 0));
  endtask

  task automatic tick;
    bit         acc;
    logic [4:0] v_acc;
    item_t      e;
    acc   = sample_valid && sample_ready && !rst;
    v_acc = sample;
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = 0;
    end else begin
      cyc++;
      if (acc) begin
        e.v       = int'(v_acc);
        e.acc_cyc = cyc;
        q.push_back(e);
        acc_count++;
      end
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          chk("spurious_commit", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.acc_cyc), 32'(e.v / 10 + 2));
          exp_has         = 1'b1;
          exp_ones        = e.v % 10;
          exp_tens        = e.v / 10;
          exp_alarm       = (e.v >= ALARM_THRESH);
          last_commit_cyc = cyc;
        end
      end
    end
    prev_busy = busy;
    check_outputs();
  endtask

  task automatic send(input int v, input int hold);
    int base;
    int n;
    base = acc_count;
    n = 0;
    sample = 5'(v);
    sample_valid = 1'b1;
    while (acc_count == base && n < 20) begin
      tick();
      n++;
    end
    sample_valid = 1'b0;
    chk("accepted", 32'(acc_count - base), 32'd1);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (hold) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    rst = 1'b1;
    sample = 5'd0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_digit_en", 32'(digit_en), 32'h3);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    rst = 1'b0;
    cyc = 0;
    repeat (20) tick();

    send(27, 24);
    send(5, 16);
    send(0, 16);
    send(31, 40);
    send(12, 24);

    // Valid held high across two samples: 24 must be taken the cycle after 19 commits.
    base = acc_count;
    n = 0;
    sample = 5'd19;
    sample_valid = 1'b1;
    while (acc_count < base + 2 && n < 40) begin
      tick();
      n++;
      if (acc_count == base + 1) sample = 5'd24;
    end
    sample_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_count - base), 32'd2);
    if (q.size() > 0) chk("b2b_gap", 32'(q[$].acc_cyc - last_commit_cyc), 32'd1);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (20) tick();
    chk("b2b_total", 32'(acc_count - base), 32'd2);
    chk("b2b_final_ones", 32'(exp_ones), 32'd4);

    // Reset in the middle of converting 29.
    sample = 5'd29;
    sample_valid = 1'b1;
    base = acc_count;
    n = 0;
    while (acc_count == base && n < 20) begin
      tick();
      n++;
    end
    sample_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(sample_ready), 32'd1);
    chk("midrst_seg", 32'(seg), 32'h7f);
    chk("midrst_digit_en", 32'(digit_en), 32'h3);
    q.delete();
    exp_has = 1'b0;
    exp_alarm = 1'b0;
    prev_busy = 1'b0;
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (30) tick();

    chk("total_accepts", 32'(acc_count), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
